// File: rtl/readout_rx_pkg.sv
// Shared types for the readout RX integrator slice.
// FSM encoding and accumulator width derivation.
package readout_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINISH
  } state_t;

  function automatic int acc_width(input int dw, input int l2d);
    return dw + l2d;
  endfunction

endpackage

// File: rtl/readout_rx_iq_window_integrator_if.sv
// Sample, control and framing bundle of the I/Q window integrator.
// The slave modport is the integrator side.
interface readout_rx_iq_window_integrator_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int MEAS_LEN_WIDTH = 16
);
  logic                         meas_len_wr_en;
  logic [MEAS_LEN_WIDTH-1:0]    meas_len_wr_data;
  logic                         meas_start;
  logic                         valid_in;
  logic signed [DATA_WIDTH-1:0] i_in;
  logic signed [DATA_WIDTH-1:0] q_in;
  logic                         valid_out;
  logic signed [DATA_WIDTH-1:0] i_out;
  logic signed [DATA_WIDTH-1:0] q_out;
  logic                         start_count;
  logic                         finish_count;
  logic                         meas_busy;
  logic                         overrun_err;

  modport master (
    output meas_len_wr_en, meas_len_wr_data, meas_start,
    output valid_in, i_in, q_in,
    input  valid_out, i_out, q_out,
    input  start_count, finish_count, meas_busy, overrun_err
  );

  modport slave (
    input  meas_len_wr_en, meas_len_wr_data, meas_start,
    input  valid_in, i_in, q_in,
    output valid_out, i_out, q_out,
    output start_count, finish_count, meas_busy, overrun_err
  );
endinterface

// File: rtl/readout_rx_iq_boxcar_acc.sv
// Per-channel boxcar accumulator: clear/load, add, and dump the
// floor-averaged block (top bits of the exact sum) to a held output.
module readout_rx_iq_boxcar_acc
  import readout_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_DECIM = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic                         dump,
  input  logic signed [DATA_WIDTH-1:0] sample,
  output logic signed [DATA_WIDTH-1:0] avg
);
  localparam int AW = acc_width(DATA_WIDTH, LOG2_DECIM);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] base;
  logic signed [AW-1:0] addend;
  logic signed [AW-1:0] sum;

  always_comb begin
    base   = clr ? '0 : acc;
    addend = en ? {{LOG2_DECIM{sample[DATA_WIDTH-1]}}, sample} : '0;
    sum    = base + addend;
  end

  // Dropping the low bits of the exact sum is an arithmetic floor shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      avg <= '0;
    end else begin
      if (clr || en)
        acc <= dump ? '0 : sum;
      if (dump)
        avg <= sum[AW-1:LOG2_DECIM];
    end
  end

endmodule

// File: rtl/readout_rx_iq_window_integrator.sv
// Integrates blocks of 2^LOG2_DECIM I/Q samples into averaged bins and
// frames each measurement with start_count / finish_count strobes.
module readout_rx_iq_window_integrator
  import readout_rx_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int LOG2_DECIM     = 3,
  parameter int MEAS_LEN_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  readout_rx_iq_window_integrator_if.slave bus
);
  state_t state, state_d;

  logic [LOG2_DECIM-1:0]     sample_cnt, sample_cnt_d;
  logic [MEAS_LEN_WIDTH-1:0] bin_cnt, bin_cnt_d;
  logic [MEAS_LEN_WIDTH-1:0] meas_len;
  logic [MEAS_LEN_WIDTH-1:0] shadow_len, shadow_len_d;
  logic valid_q, valid_d;
  logic start_q, start_d;
  logic fin_q, fin_d;
  logic overrun_q;
  logic acc_clr, acc_en, acc_dump;
  logic last_sample, last_bin;

  assign last_sample = &sample_cnt;
  assign last_bin    = bin_cnt == shadow_len - MEAS_LEN_WIDTH'(1);

  always_comb begin
    state_d      = state;
    sample_cnt_d = sample_cnt;
    bin_cnt_d    = bin_cnt;
    shadow_len_d = shadow_len;
    valid_d      = 1'b0;
    start_d      = 1'b0;
    fin_d        = 1'b0;
    acc_clr      = 1'b0;
    acc_en       = 1'b0;
    acc_dump     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.meas_start) begin
          state_d      = ACCUM;
          shadow_len_d = meas_len;
          bin_cnt_d    = '0;
          acc_clr      = 1'b1;
          acc_en       = bus.valid_in;
          sample_cnt_d = bus.valid_in ? LOG2_DECIM'(1) : '0;
        end
      end
      ACCUM: begin
        if (bus.valid_in) begin
          acc_en       = 1'b1;
          sample_cnt_d = sample_cnt + LOG2_DECIM'(1);
          if (last_sample) begin
            acc_dump  = 1'b1;
            valid_d   = 1'b1;
            start_d   = bin_cnt == '0;
            bin_cnt_d = bin_cnt + MEAS_LEN_WIDTH'(1);
            if (last_bin)
              state_d = FINISH;
          end
        end
      end
      FINISH: begin
        fin_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bin_cnt    <= '0;
      shadow_len <= MEAS_LEN_WIDTH'(1);
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      state      <= state_d;
      sample_cnt <= sample_cnt_d;
      bin_cnt    <= bin_cnt_d;
      shadow_len <= shadow_len_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      fin_q      <= fin_d;
    end
  end

  // Zero-length measurements are meaningless; such writes keep the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_len  <= MEAS_LEN_WIDTH'(1);
      overrun_q <= 1'b0;
    end else begin
      if (bus.meas_len_wr_en && |bus.meas_len_wr_data)
        meas_len <= bus.meas_len_wr_data;
      if (bus.meas_start && state != IDLE)
        overrun_q <= 1'b1;
    end
  end

  assign bus.valid_out    = valid_q;
  assign bus.start_count  = start_q;
  assign bus.finish_count = fin_q;
  assign bus.meas_busy    = state != IDLE;
  assign bus.overrun_err  = overrun_q;

  readout_rx_iq_boxcar_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2_DECIM (LOG2_DECIM)
  ) u_acc_i (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .en     (acc_en),
    .dump   (acc_dump),
    .sample (bus.i_in),
    .avg    (bus.i_out)
  );

  readout_rx_iq_boxcar_acc #(
    .DATA_WIDTH (DATA_WIDTH),
    .LOG2_DECIM (LOG2_DECIM)
  ) u_acc_q (
    .clk    (clk),
    .rst    (rst),
    .clr    (acc_clr),
    .en     (acc_en),
    .dump   (acc_dump),
    .sample (bus.q_in),
    .avg    (bus.q_out)
  );

endmodule

// File: tb/tb_readout_rx_iq_window_integrator.sv
// Scoreboard bench for the I/Q window integrator (decimation 4).
// Expected bins are queued as samples are driven and popped on valid_out.
module tb_readout_rx_iq_window_integrator;
  localparam int DW  = 16;
  localparam int L2D = 2;
  localparam int MLW = 16;
  localparam int DEC = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  readout_rx_iq_window_integrator_if #(
    .DATA_WIDTH     (DW),
    .MEAS_LEN_WIDTH (MLW)
  ) bus ();

  readout_rx_iq_window_integrator #(
    .DATA_WIDTH     (DW),
    .LOG2_DECIM     (L2D),
    .MEAS_LEN_WIDTH (MLW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int i;
    int q;
    bit st;
    int c;
  } bin_t;

  bin_t exp_q[$];
  int   fin_q[$];
  bin_t e;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int m_state = 0, m_cnt = 0, m_si = 0, m_sq = 0;
  int m_bin = 0, m_len = 1, m_shadow = 1;
  bit m_ovr = 0;

  function automatic int fdiv(input int s);
    return (s >= 0) ? s / DEC : -((-s + DEC - 1) / DEC);
  endfunction

  task automatic step(input bit v, input logic signed [15:0] i,
                      input logic signed [15:0] q, input bit st,
                      input bit wr, input logic [15:0] wd);
    @(posedge clk);
    #1;
    bus.valid_in         = v;
    bus.i_in             = i;
    bus.q_in             = q;
    bus.meas_start       = st;
    bus.meas_len_wr_en   = wr;
    bus.meas_len_wr_data = wd;
    case (m_state)
      0: if (st) begin
        m_shadow = m_len;
        m_bin    = 0;
        m_state  = 1;
        m_si     = v ? int'(i) : 0;
        m_sq     = v ? int'(q) : 0;
        m_cnt    = v ? 1 : 0;
      end
      1: begin
        if (st) m_ovr = 1;
        if (v) begin
          m_si += int'(i);
          m_sq += int'(q);
          m_cnt++;
          if (m_cnt == DEC) begin
            exp_q.push_back('{fdiv(m_si), fdiv(m_sq), m_bin == 0, cyc + 1});
            m_bin++;
            m_cnt = 0;
            m_si  = 0;
            m_sq  = 0;
            if (m_bin == m_shadow) begin
              m_state = 2;
              fin_q.push_back(cyc + 2);
            end
          end
        end
      end
      default: begin
        if (st) m_ovr = 1;
        m_state = 0;
      end
    endcase
    if (wr && wd != 0) m_len = int'(wd);
  endtask

  task automatic samp(input logic signed [15:0] i, input logic signed [15:0] q);
    step(1'b1, i, q, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic rsamp();
    samp(16'($urandom), 16'($urandom));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++)
      step(1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 16'd0);
  endtask

  task automatic start(input bit v, input logic signed [15:0] i,
                       input logic signed [15:0] q);
    step(v, i, q, 1'b1, 1'b0, 16'd0);
  endtask

  task automatic wlen(input logic [15:0] d);
    step(1'b0, 16'sd0, 16'sd0, 1'b0, 1'b1, d);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() > 0 && exp_q[0].c < cyc) begin
        chk("vout_missing", cyc, exp_q[0].c);
        void'(exp_q.pop_front());
      end
      if (fin_q.size() > 0 && fin_q[0] < cyc) begin
        chk("finish_missing", cyc, fin_q[0]);
        void'(fin_q.pop_front());
      end
      if (bus.valid_out) begin
        if (exp_q.size() == 0) begin
          chk("vout_unexpected", bus.valid_out, 0);
        end else begin
          e = exp_q.pop_front();
          chk("vout_cycle", cyc, e.c);
          chk("i_out", bus.i_out, e.i);
          chk("q_out", bus.q_out, e.q);
          chk("start_count", bus.start_count, e.st);
        end
      end else if (bus.start_count) begin
        chk("start_without_vout", bus.start_count, 0);
      end
      if (bus.finish_count) begin
        if (fin_q.size() == 0)
          chk("finish_unexpected", bus.finish_count, 0);
        else
          chk("finish_cycle", cyc, fin_q.pop_front());
        chk("finish_vout", bus.valid_out, 0);
      end
    end
  end

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_vout"}, bus.valid_out, 0);
    chk({tag, "_iout"}, bus.i_out, 0);
    chk({tag, "_qout"}, bus.q_out, 0);
    chk({tag, "_start"}, bus.start_count, 0);
    chk({tag, "_finish"}, bus.finish_count, 0);
    chk({tag, "_busy"}, bus.meas_busy, 0);
    chk({tag, "_ovr"}, bus.overrun_err, 0);
  endtask

  initial begin
    rst                  = 1'b1;
    bus.valid_in         = 1'b0;
    bus.i_in             = '0;
    bus.q_in             = '0;
    bus.meas_start       = 1'b0;
    bus.meas_len_wr_en   = 1'b0;
    bus.meas_len_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // default length after reset is one bin
    start(1'b0, 16'sd0, 16'sd0);
    for (int k = 0; k < 4; k++) samp(16'sd8, -16'sd12);
    idle(3);

    // contiguous 3-bin measurement
    wlen(16'd3);
    start(1'b0, 16'sd0, 16'sd0);
    samp(16'sd100, -16'sd50);
    chk("busy_in_accum", bus.meas_busy, 1);
    for (int k = 1; k < 12; k++) samp(16'sd100, -16'sd50);
    idle(3);
    chk("busy_after_finish", bus.meas_busy, 0);

    // floor behaviour with meas_start carrying the first sample
    wlen(16'd1);
    start(1'b1, 16'sd1, -16'sd1);
    samp(16'sd1, -16'sd1);
    samp(16'sd1, -16'sd1);
    samp(16'sd2, -16'sd2);
    idle(3);
    start(1'b0, 16'sd0, 16'sd0);
    for (int k = 0; k < 4; k++) samp(16'sh7FFF, 16'sh8000);
    idle(3);
    start(1'b0, 16'sd0, 16'sd0);
    for (int k = 0; k < 4; k++) samp(16'sh8000, 16'sh7FFF);
    idle(3);

    // gapped input, valid every third cycle
    wlen(16'd2);
    start(1'b0, 16'sd0, 16'sd0);
    for (int k = 0; k < 8; k++) begin
      rsamp();
      idle(2);
    end
    idle(3);

    // zero write ignored, mid-window write applies to next measurement
    wlen(16'd3);
    wlen(16'd0);
    start(1'b0, 16'sd0, 16'sd0);
    for (int k = 0; k < 12; k++) begin
      if (k == 5)
        step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b1, 16'd5);
      else
        rsamp();
    end
    idle(3);
    start(1'b0, 16'sd0, 16'sd0);
    for (int k = 0; k < 20; k++) rsamp();
    idle(3);

    // meas_start while busy
    wlen(16'd3);
    start(1'b0, 16'sd0, 16'sd0);
    for (int k = 0; k < 6; k++) rsamp();
    step(1'b1, 16'($urandom), 16'($urandom), 1'b1, 1'b0, 16'd0);
    for (int k = 0; k < 5; k++) rsamp();
    idle(3);
    chk("overrun_set", bus.overrun_err, m_ovr);
    idle(5);
    chk("overrun_sticky", bus.overrun_err, 1);

    // asynchronous reset after bin 1 of 3
    start(1'b0, 16'sd0, 16'sd0);
    for (int k = 0; k < 5; k++) samp(16'sd300, -16'sd200);
    idle(1);
    @(posedge clk);
    #2;
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    #1;
    chk_outs_zero("async_rst");
    exp_q.delete();
    fin_q.delete();
    m_state = 0;
    m_cnt   = 0;
    m_len   = 1;
    m_ovr   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wlen(16'd3);
    start(1'b0, 16'sd0, 16'sd0);
    for (int k = 0; k < 12; k++) rsamp();
    idle(8);

    chk("bins_pending", exp_q.size(), 0);
    chk("finish_pending", fin_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
